pipelined_muldiv_alu: RTL
=========================

Name: pipelined_muldiv_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute-stage ALU.
- Keeps all single-cycle integer ops at WIDTH bits and adds iterative signed/unsigned multiply and divide producing HI/LO.
- Uses a valid/ready handshake on both sides so the EX stage can stall on long ops.
- Sits in EX between operand forwarding and the EX/MEM register; the pipeline flush drives kill.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of two).
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from operand a.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- op  in  AluOp  operation select (shared package enum).
- a  in  WIDTH  operand 1 (shift amount source for shifts).
- b  in  WIDTH  operand 2.
- kill  in  1  abort any accepted/in-flight op (pipeline flush).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  primary result (LO for mul/div).
- hi  out  WIDTH  product high half / remainder; 0 for single-cycle ops.
- overflow  out  1  signed overflow for ADD/SUB only.
- div_by_zero  out  1  DIV/DIVU with b==0.
- illegal_op  out  1  op not in decoded set.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, in_ready=1, out_valid=0, result=hi=0, all flags=0. Reset mid-operation discards work; no partial result is ever presented.
- States:
  - IDLE: in_ready=1; accept on in_valid&&in_ready.
  - MUL / DIV: iterating, in_ready=0.
  - FIX: sign correction for the signed variants.
  - DONE: out_valid=1, in_ready=0.
- Single-cycle ops (ADD, ADDU, SUB, SUBU, SLL/SRL/SRA and their variable forms, AND, OR, XOR, NOR, SLT, SLTU): IDLE→DONE; out_valid at the edge after acceptance (latency 1).
  - Shift amount = a[SHAMT_W-1:0]; shifts operate on b.
  - SLT/SLTU return zero-extended 1/0.
- overflow, ADD: set iff sign(a)==sign(b) and sign(result)!=sign(a).
- overflow, SUB: set iff sign(a)!=sign(b) and sign(result)!=sign(a).
- overflow is 0 for all other ops. Result is still written; trapping is the pipeline's job.
- MULT/MULTU: radix-2 shift-add on operand magnitudes (signed: absolute values) over WIDTH iterations in MUL, then one FIX cycle.
  - FIX negates the 2·WIDTH product if signs differ; MULTU passes through unchanged.
  - out_valid exactly WIDTH+2 edges after acceptance. {hi,result} = full product.
- DIV/DIVU: restoring division on magnitudes over WIDTH iterations, then FIX; same latency WIDTH+2.
  - Quotient (result) is negated if operand signs differ.
  - Remainder (hi) takes the sign of a.
  - b==0: skip iteration, DONE after 1 edge, result=all ones, hi=a, div_by_zero=1.
  - Signed MIN/−1: result=MIN, hi=0, no flag.
- Unknown op: DONE after 1 edge, result=hi=0, illegal_op=1.
- DONE: outputs held stable until out_valid&&out_ready, then IDLE. No back-to-back accept in the same cycle as the handoff; in_ready rises the following cycle.
- kill=1 at an edge: return to IDLE, out_valid=0, flags cleared. kill overrides acceptance and completion in the same cycle. rst overrides kill.
- Iteration counter is $clog2(WIDTH)+1 bits wide, cleared on accept; there is no wrap.

Decomposition:
- Shared alu_pkg holds:
  - AluOp enum: existing ALU encodings plus ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU.
  - State enum.
  - Helper functions abs_val and is_long_op.
- One sub-module, muldiv_iter: owns the magnitude registers, counter and shift-add/restoring step, with start/done handshake internal to the top.
- The top keeps the combinational single-cycle ALU, the FSM, sign fixup and output registers.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 → after 1 edge out_valid=1, result=0x80000000, overflow=1. ADDU with same operands → overflow=0.
- MULT a=−3 (0xFFFFFFFD), b=7 → out_valid at edge 34, {hi,result}=0xFFFFFFFF_FFFFFFEB. MULTU same operands → hi=6, result=0xFFFFFFEB.
- DIV a=−7, b=2 → result=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=0 → after 1 edge result=0xFFFFFFFF, hi=7, div_by_zero=1.
- DIV a=0x80000000, b=0xFFFFFFFF → result=0x80000000, hi=0, no flags.
- Backpressure: hold out_ready=0 for 5 cycles after a MULT completes → outputs stable, in_ready=0, in_valid ignored. out_ready=1 → IDLE next edge.
- Assert kill at iteration 10 of a DIV → IDLE next edge, out_valid never asserted. Then issue SRA a=4, b=0x80000000 → result=0xF8000000 after 1 edge. Repeat the DIV with rst instead of kill → same behaviour.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the execute-stage ALU with iterative multiply/divide.
package alu_pkg;

  // Widest datapath the shared helpers can handle.
  localparam int MAX_W = 128;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_ADDU  = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SUBU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_SLLV  = 5'd13,
    ALU_SRLV  = 5'd14,
    ALU_SRAV  = 5'd15,
    ALU_MULT  = 5'd16,
    ALU_MULTU = 5'd17,
    ALU_DIV   = 5'd18,
    ALU_DIVU  = 5'd19
  } AluOp;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } AluState;

  // Two's-complement magnitude; callers zero-extend into MAX_W and truncate back.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic is_long_op(input AluOp op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned radix-2 shift-add multiplier / restoring divider, one bit per step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             start,
  input  logic             step,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] magA,
  input  logic [WIDTH-1:0] magB,
  output logic             lastStep,
  output logic [WIDTH-1:0] prodHi,
  output logic [WIDTH-1:0] prodLo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] count;
  logic             mode;
  logic [WIDTH-1:0] hiReg, loReg, bReg;
  logic [WIDTH:0]   mulSum, divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divGe;

  // hiReg:loReg is the running product for multiply, remainder:quotient for divide.
  always_comb begin
    mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, bReg} : '0);
    divShift = {hiReg, loReg[WIDTH-1]};
    divGe    = divShift >= {1'b0, bReg};
    divDiff  = WIDTH'(divShift - {1'b0, bReg});
  end

  assign lastStep = step && (count == CNT_W'(WIDTH - 1));
  assign prodHi   = hiReg;
  assign prodLo   = loReg;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: datapath registers carry no reset; they are reloaded on every start and unobserved otherwise.
  always_ff @(posedge clk) begin
    if (start) begin
      count <= '0;
      mode  <= isDiv;
      hiReg <= '0;
      loReg <= magA;
      bReg  <= magB;
    end else if (step) begin
      count <= count + 1'b1;
      if (mode) begin
        hiReg <= divGe ? divDiff : divShift[WIDTH-1:0];
        loReg <= {loReg[WIDTH-2:0], divGe};
      end else begin
        {hiReg, loReg} <= {mulSum, loReg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// EX-stage ALU: single-cycle integer ops plus iterative mul/div behind valid/ready.
module pipelined_muldiv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  AluOp             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  AluState state, nextState;

  logic             start, lastStep;
  logic             longOp, divOp, signedOp;
  logic [WIDTH-1:0] magA, magB, iterHi, iterLo;
  logic [WIDTH-1:0] sum, diff, aluResult;
  logic             aluOverflow, aluIllegal;
  logic [SHAMT_W-1:0] shamt;

  logic               fixIsDiv, fixNegQ, fixNegR;
  logic [2*WIDTH-1:0] prodFull, fixProd;
  logic [WIDTH-1:0]   fixQuo, fixRem;

  assign longOp   = is_long_op(op);
  assign divOp    = (op == ALU_DIV) || (op == ALU_DIVU);
  assign signedOp = (op == ALU_MULT) || (op == ALU_DIV);
  assign magA     = WIDTH'(abs_val(MAX_W'(a), signedOp && a[WIDTH-1]));
  assign magB     = WIDTH'(abs_val(MAX_W'(b), signedOp && b[WIDTH-1]));
  assign shamt    = a[SHAMT_W-1:0];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .start    (start),
    .step     ((state == ST_MUL) || (state == ST_DIV)),
    .isDiv    (divOp),
    .magA     (magA),
    .magB     (magB),
    .lastStep (lastStep),
    .prodHi   (iterHi),
    .prodLo   (iterLo)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum         = a + b;
    diff        = a - b;
    aluResult   = '0;
    aluOverflow = 1'b0;
    aluIllegal  = 1'b0;
    case (op)
      ALU_ADD: begin
        aluResult   = sum;
        aluOverflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_ADDU: aluResult = sum;
      ALU_SUB: begin
        aluResult   = diff;
        aluOverflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUBU:            aluResult = diff;
      ALU_AND:             aluResult = a & b;
      ALU_OR:              aluResult = a | b;
      ALU_XOR:             aluResult = a ^ b;
      ALU_NOR:             aluResult = ~(a | b);
      ALU_SLT:             aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:            aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL, ALU_SLLV:   aluResult = b << shamt;
      ALU_SRL, ALU_SRLV:   aluResult = b >> shamt;
      ALU_SRA, ALU_SRAV:   aluResult = $signed(b) >>> shamt;
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: aluResult = '0;
      default:             aluIllegal = 1'b1;
    endcase
  end

  always_comb begin
    prodFull = {iterHi, iterLo};
    fixProd  = fixNegQ ? -prodFull : prodFull;
    fixQuo   = fixNegQ ? -iterLo : iterLo;
    fixRem   = fixNegR ? -iterHi : iterHi;
  end

  always_comb begin
    nextState = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (longOp && !(divOp && b == '0)) begin
            start     = 1'b1;
            nextState = divOp ? ST_DIV : ST_MUL;
          end else begin
            nextState = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: if (lastStep) nextState = ST_FIX;
      ST_FIX:         nextState = ST_DONE;
      ST_DONE:        if (out_ready) nextState = ST_IDLE;
      default:        nextState = ST_IDLE;
    endcase
    if (kill) begin
      nextState = ST_IDLE;
      start     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  // Flush clears the result registers as well, so a killed op leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      result      <= '0;
      hi          <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      fixIsDiv    <= 1'b0;
      fixNegQ     <= 1'b0;
      fixNegR     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            result      <= '0;
            hi          <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            if (longOp) begin
              fixIsDiv <= divOp;
              fixNegQ  <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
              fixNegR  <= signedOp && a[WIDTH-1];
              if (divOp && b == '0) begin
                result      <= '1;
                hi          <= a;
                div_by_zero <= 1'b1;
              end
            end else if (aluIllegal) begin
              illegal_op <= 1'b1;
            end else begin
              result   <= aluResult;
              overflow <= aluOverflow;
            end
          end
        end
        ST_FIX: begin
          if (fixIsDiv) begin
            result <= fixQuo;
            hi     <= fixRem;
          end else begin
            {hi, result} <= fixProd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
